// File: rtl/router_packet_arbiter.sv
// ---------------------------------------------------------------------------
// router_packet_arbiter
//
// Packet-level round-robin arbiter for the BrainDrizzle router. Merges NUM_IN
// ingress word streams (0=top, 1=bot, 2=BD) onto one registered egress stream.
// A packet is a run of DATA_W-bit words; bit DATA_W-1 is the tail flag and is
// set only on the last word. A grant is held from the first word to the tail,
// so packets are never interleaved.
//
// Optional feature macro: PKT_TIMEOUT_EN
//   When defined, a per-grant word counter forces the tail bit on word number
//   MAX_PKT_LEN of a packet that has not ended yet, releases the grant and
//   pulses err_timeout for one cycle. The rest of that packet is arbitrated
//   later as a new packet. When undefined, err_timeout is tied low and a grant
//   is held until a real tail arrives.
//
// Ports:
//   clk          router clock
//   reset        asynchronous, active-high reset
//   in_data      NUM_IN*DATA_W concatenated ingress words, port i at
//                [i*DATA_W +: DATA_W]
//   in_valid     per-port word available
//   in_ready     per-port word accepted this cycle (combinational)
//   out_data     registered egress word
//   out_valid    registered egress valid
//   out_ready    downstream accepts the egress word
//   grant_id     index of the port currently (or last) granted
//   busy         high while a packet grant is held (mirrors FSM state BUSY)
//   err_timeout  one-cycle pulse on forced packet termination
//
// Handshake: on every interface a word moves on a rising clk edge exactly
// when valid and ready are both high in the cycle before that edge. A source
// holds valid and data stable until the word moves; ready may depend
// combinationally on valid. The egress stage holds out_data/out_valid stable
// while out_valid=1 and out_ready=0.
//
// The FSM state is externally visible: busy=1 exactly when the FSM is in
// BUSY, and grant_id holds the granted port.
//
// Supports NUM_IN from 2 to 4 (grant_id is 2 bits wide).
// ---------------------------------------------------------------------------
module router_packet_arbiter #(
  parameter int NUM_IN      = 3,
  parameter int DATA_W      = 11,
  parameter int MAX_PKT_LEN = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               grant_id,
  output logic                     busy,
  output logic                     err_timeout
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t              r_state;
  logic [1:0]          r_rr_ptr;     // port searched first in the next IDLE
  logic [1:0]          r_grant;
  logic                r_busy;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;

  // -------------------------------------------------------------------------
  // Combinational signals
  // -------------------------------------------------------------------------
  logic [3:0]          w_req_pad;    // in_valid widened so a 2-bit index always fits
  logic                w_slot_free;  // egress register can take a word this cycle
  logic                w_gnt_valid;  // granted port has a word available
  logic                w_xfer;       // a word moves from the granted port this cycle
  logic [DATA_W-1:0]   w_word;       // word presented by the granted port
  logic [DATA_W-1:0]   w_out_word;   // word as written into the egress register
  logic                w_release;    // this transfer ends the grant
  logic [1:0]          w_rr_next;
  logic                w_req_hit;
  logic [1:0]          w_req_pick;
  logic [2:0]          w_sum;

  assign w_req_pad   = 4'(in_valid);
  assign w_slot_free = ~r_out_valid | out_ready;
  assign w_gnt_valid = w_req_pad[r_grant];
  assign w_xfer      = (r_state == ST_BUSY) & w_gnt_valid & w_slot_free;

  // Granted-port data mux, unrolled over a constant port index.
  always_comb begin
    w_word = '0;
    for (int p = 0; p < NUM_IN; p++) begin
      if (r_grant == 2'(p)) begin
        w_word = in_data[p*DATA_W +: DATA_W];
      end
    end
  end

  // Only the granted port sees ready, and only while BUSY with room in the
  // egress register. No word moves during the IDLE arbitration cycle.
  always_comb begin
    in_ready = '0;
    for (int p = 0; p < NUM_IN; p++) begin
      in_ready[p] = (r_state == ST_BUSY) && (r_grant == 2'(p)) &&
                    in_valid[p] && w_slot_free;
    end
  end

  // Rotating-priority search: first requester at or after r_rr_ptr, modulo
  // NUM_IN. Only the first hit is kept.
  always_comb begin
    w_req_hit  = 1'b0;
    w_req_pick = '0;
    w_sum      = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_sum = {1'b0, r_rr_ptr} + 3'(k);
      if (w_sum >= 3'(NUM_IN)) begin
        w_sum = w_sum - 3'(NUM_IN);
      end
      if (!w_req_hit && w_req_pad[w_sum[1:0]]) begin
        w_req_hit  = 1'b1;
        w_req_pick = w_sum[1:0];
      end
    end
  end

  // The port just served gets the lowest priority next time.
  assign w_rr_next = (r_grant == 2'(NUM_IN - 1)) ? 2'd0 : r_grant + 2'd1;

`ifdef PKT_TIMEOUT_EN
  localparam int            CW       = $clog2(MAX_PKT_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_PKT_LEN - 1);

  logic [CW-1:0] r_word_cnt;    // words already transferred in this grant
  logic          r_err_timeout;
  logic          w_timeout;

  // The word being transferred is number r_word_cnt+1; when that reaches
  // MAX_PKT_LEN without a tail, the packet is cut here.
  assign w_timeout   = w_xfer & ~w_word[DATA_W-1] & (r_word_cnt == CNT_LAST);
  assign w_out_word  = {w_word[DATA_W-1] | w_timeout, w_word[DATA_W-2:0]};
  assign w_release   = w_xfer & (w_word[DATA_W-1] | w_timeout);
  assign err_timeout = r_err_timeout;
`else
  assign w_out_word  = w_word;
  assign w_release   = w_xfer & w_word[DATA_W-1];
  assign err_timeout = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // FSM, egress register and grant bookkeeping
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= '0;
      r_grant       <= '0;
      r_busy        <= 1'b0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
`ifdef PKT_TIMEOUT_EN
      r_word_cnt    <= '0;
      r_err_timeout <= 1'b0;
`endif
    end else begin
`ifdef PKT_TIMEOUT_EN
      r_err_timeout <= w_timeout;
`endif

      // Egress stage: load on transfer, otherwise drain when accepted.
      // out_data is left untouched when draining so it only changes on load.
      if (w_xfer) begin
        r_out_data  <= w_out_word;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_req_hit) begin
            r_grant    <= w_req_pick;
            r_busy     <= 1'b1;
            r_state    <= ST_BUSY;
`ifdef PKT_TIMEOUT_EN
            r_word_cnt <= '0;
`endif
          end
        end
        ST_BUSY: begin
`ifdef PKT_TIMEOUT_EN
          if (w_xfer) begin
            r_word_cnt <= r_word_cnt + 1'b1;
          end
`endif
          // grant_id keeps its value after release; only rr_ptr moves on.
          if (w_release) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_rr_ptr <= w_rr_next;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign grant_id  = r_grant;
  assign busy      = r_busy;

endmodule

// File: tb/tb_router_packet_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for router_packet_arbiter (default parameters: 3 ports, 11-bit
// words, MAX_PKT_LEN=16). Per-port source queues feed the DUT; every egress
// word accepted downstream is logged with its cycle number and compared with
// the expected sequence each scenario task builds.
// ---------------------------------------------------------------------------
module tb_router_packet_arbiter;

  localparam int NI = 3;
  localparam int DW = 11;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            reset;
  logic [NI*DW-1:0] in_data;
  logic [NI-1:0]   in_valid;
  logic [NI-1:0]   in_ready;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      grant_id;
  logic            busy;
  logic            err_timeout;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  router_packet_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] src_q[NI][$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int            got_cyc[$];
  int            gap_after[NI];
  int            gap_len[NI];
  int            gap_left[NI];
  int            sent_cnt[NI];
  logic [NI-1:0] acc;
  int            ready_mode;   // 0: out_ready=1, 1: toggle every cycle
  int            err_pulses;
  int            errors;
  int            checks;

  // ---------------- driver + monitor ----------------
  // Inputs change on the falling edge; everything is sampled 1 time unit
  // before the rising edge, when inputs and outputs are both settled.
  initial begin
    acc        = '0;
    in_valid   = '0;
    in_data    = '0;
    out_ready  = 1'b1;
    err_pulses = 0;
    for (int p = 0; p < NI; p++) begin
      gap_after[p] = 0; gap_len[p] = 0; gap_left[p] = 0; sent_cnt[p] = 0;
    end
    forever begin
      @(negedge clk);
      for (int p = 0; p < NI; p++) begin
        if (acc[p]) begin
          void'(src_q[p].pop_front());
          sent_cnt[p]++;
          if (sent_cnt[p] == gap_after[p]) gap_left[p] = gap_len[p];
        end else if (gap_left[p] > 0) begin
          gap_left[p]--;
        end
        in_valid[p] = (src_q[p].size() > 0) && (gap_left[p] == 0);
        in_data[p*DW +: DW] = (src_q[p].size() > 0) ? src_q[p][0] : '0;
      end
      out_ready = (ready_mode == 1) ? ~out_ready : 1'b1;
      #4;
      acc = reset ? '0 : (in_valid & in_ready);
      if (!reset && out_valid && out_ready) begin
        got_q.push_back(out_data);
        got_cyc.push_back(int'(cyc));
      end
      if (!reset && err_timeout) err_pulses++;
    end
  end

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    reset = 1'b1;
    ready_mode = 0;
    repeat (2) @(negedge clk);
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h exp=000", out_data); end
    checks++; if (in_ready !== '0) begin errors++; $display("FAIL reset_in_ready got=%b exp=000", in_ready); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err_timeout got=%b exp=0", err_timeout); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL idle_no_request busy=%b out_valid=%b exp 0/0", busy, out_valid);
    end
  endtask

  task automatic test_single();
    int c, n;
    logic [DW-1:0] w, g;
    @(negedge clk); #1;
    c = int'(cyc);
    for (int i = 1; i <= 6; i++) begin
      w = (i == 6) ? 11'h406 : 11'(i);
      src_q[0].push_back(w);
      exp_q.push_back(w);
    end
    repeat (2) @(negedge clk);
    #2;
    checks++; if (busy !== 1'b1 || grant_id !== 2'd0) begin
      errors++; $display("FAIL single_grant busy=%b grant=%0d exp 1/0", busy, grant_id);
    end
    n = 0;
    while (got_q.size() < 6 && n < 200) begin @(negedge clk); n++; end
    checks++; if (got_q.size() < 6) begin errors++; $display("FAIL single_timeout got=%0d words exp=6", got_q.size()); end
    checks++; if (got_cyc.size() > 0 && got_cyc[0] !== c + 3) begin
      errors++; $display("FAIL single_latency first_out_cycle=%0d exp=%0d", got_cyc[0], c + 3);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      w = exp_q.pop_front(); g = got_q.pop_front(); void'(got_cyc.pop_front());
      checks++; if (g !== w) begin errors++; $display("FAIL single_word got=%h exp=%h", g, w); end
    end
    repeat (2) @(negedge clk);
    #2;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || grant_id !== 2'd0) begin
      errors++; $display("FAIL single_release busy=%b out_valid=%b grant=%0d exp 0/0/0", busy, out_valid, grant_id);
    end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  // rr_ptr is 1 after the single-packet test, so bot is served first.
  task automatic test_round_robin();
    int n;
    logic [DW-1:0] w, g;
    logic [DW-1:0] hd[NI];
    hd[0] = 11'h0A1; hd[1] = 11'h0B1; hd[2] = 11'h0C1;
    @(negedge clk); #1;
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < NI; p++) begin
        src_q[p].push_back(hd[p]);
        src_q[p].push_back(hd[p] + 11'h401);
      end
    end
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= NI; k++) begin
        exp_q.push_back(hd[k % NI]);
        exp_q.push_back(hd[k % NI] + 11'h401);
      end
    end
    n = 0;
    while (got_q.size() < 12 && n < 300) begin @(negedge clk); n++; end
    checks++; if (got_q.size() < 12) begin errors++; $display("FAIL rr_timeout got=%0d words exp=12", got_q.size()); end
    for (int i = 1; i < got_cyc.size(); i++) begin
      checks++; if (got_cyc[i] - got_cyc[i-1] !== ((i % 2 == 1) ? 1 : 2)) begin
        errors++; $display("FAIL rr_spacing idx=%0d gap=%0d exp=%0d", i, got_cyc[i] - got_cyc[i-1], (i % 2 == 1) ? 1 : 2);
      end
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      w = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== w) begin errors++; $display("FAIL rr_order got=%h exp=%h", g, w); end
    end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  task automatic test_backpressure();
    int n, stalls;
    logic prev_stall;
    logic [DW-1:0] prev_data, w, g;
    @(negedge clk); #1;
    for (int i = 1; i <= 6; i++) begin
      w = (i == 6) ? 11'h4B6 : 11'h0B0 + 11'(i);
      src_q[1].push_back(w);
      exp_q.push_back(w);
    end
    ready_mode = 1;
    prev_stall = 1'b0; prev_data = '0; stalls = 0; n = 0;
    while (got_q.size() < 6 && n < 200) begin
      @(negedge clk); #4;
      if (prev_stall) begin
        checks++; if (out_valid !== 1'b1 || out_data !== prev_data) begin
          errors++; $display("FAIL bp_hold out_valid=%b data=%h exp 1/%h", out_valid, out_data, prev_data);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (prev_stall) begin
        stalls++;
        checks++; if (in_ready !== '0) begin errors++; $display("FAIL bp_in_ready got=%b exp=000", in_ready); end
      end
      n++;
    end
    ready_mode = 0;
    checks++; if (got_q.size() < 6 || stalls == 0) begin
      errors++; $display("FAIL bp_progress words=%0d stalls=%0d exp 6/>0", got_q.size(), stalls);
    end
    repeat (3) @(negedge clk);
    checks++; if (got_q.size() !== 6) begin errors++; $display("FAIL bp_count got=%0d exp=6", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      w = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== w) begin errors++; $display("FAIL bp_word got=%h exp=%h", g, w); end
    end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  // rr_ptr is 2 here; port 2 pauses 5 cycles after its 2nd word.
  task automatic test_hold();
    int n;
    logic [DW-1:0] w, g;
    @(negedge clk); #1;
    sent_cnt[2] = 0; gap_after[2] = 2; gap_len[2] = 5;
    src_q[2].push_back(11'h0D1); src_q[2].push_back(11'h0D2);
    src_q[2].push_back(11'h0D3); src_q[2].push_back(11'h4D4);
    src_q[0].push_back(11'h0E1); src_q[0].push_back(11'h4E2);
    src_q[1].push_back(11'h0F1); src_q[1].push_back(11'h4F2);
    exp_q.push_back(11'h0D1); exp_q.push_back(11'h0D2);
    exp_q.push_back(11'h0D3); exp_q.push_back(11'h4D4);
    exp_q.push_back(11'h0E1); exp_q.push_back(11'h4E2);
    exp_q.push_back(11'h0F1); exp_q.push_back(11'h4F2);
    n = 0;
    while (got_q.size() < 8 && n < 300) begin
      @(negedge clk); #2;
      if (gap_left[2] > 0) begin
        checks++; if (busy !== 1'b1 || grant_id !== 2'd2 || in_ready !== '0) begin
          errors++; $display("FAIL hold_grant busy=%b grant=%0d in_ready=%b exp 1/2/000", busy, grant_id, in_ready);
        end
      end
      n++;
    end
    gap_after[2] = 0; gap_len[2] = 0;
    checks++; if (got_q.size() < 8) begin errors++; $display("FAIL hold_timeout got=%0d words exp=8", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      w = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== w) begin errors++; $display("FAIL hold_order got=%h exp=%h", g, w); end
    end
    repeat (2) @(negedge clk);
    #2;
    checks++; if (busy !== 1'b0 || grant_id !== 2'd1) begin
      errors++; $display("FAIL hold_final busy=%b grant=%0d exp 0/1", busy, grant_id);
    end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

  task automatic test_reset_mid();
    int n;
    logic [DW-1:0] w, g;
    @(negedge clk); #1;
    for (int i = 1; i <= 6; i++) src_q[1].push_back((i == 6) ? 11'h466 : 11'h060 + 11'(i));
    n = 0;
    while (got_q.size() < 3 && n < 100) begin @(negedge clk); n++; end
    checks++; if (got_q.size() < 3) begin errors++; $display("FAIL rmid_progress got=%0d words exp=3", got_q.size()); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0 || grant_id !== 2'd0 ||
                  in_ready !== '0 || err_timeout !== 1'b0) begin
      errors++; $display("FAIL rmid_async ov=%b od=%h busy=%b grant=%0d rdy=%b err=%b exp all 0",
                         out_valid, out_data, busy, grant_id, in_ready, err_timeout);
    end
    for (int p = 0; p < NI; p++) begin src_q[p].delete(); sent_cnt[p] = 0; end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk); #1;
    src_q[0].push_back(11'h411); src_q[1].push_back(11'h422); src_q[2].push_back(11'h433);
    exp_q.push_back(11'h411); exp_q.push_back(11'h422); exp_q.push_back(11'h433);
    n = 0;
    while (got_q.size() < 3 && n < 100) begin @(negedge clk); n++; end
    checks++; if (got_q.size() < 3) begin errors++; $display("FAIL rmid_restart got=%0d words exp=3", got_q.size()); end
    for (int i = 1; i < got_cyc.size(); i++) begin
      checks++; if (got_cyc[i] - got_cyc[i-1] !== 2) begin
        errors++; $display("FAIL rmid_single_spacing idx=%0d gap=%0d exp=2", i, got_cyc[i] - got_cyc[i-1]);
      end
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      w = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== w) begin errors++; $display("FAIL rmid_order got=%h exp=%h", g, w); end
    end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask

`ifdef PKT_TIMEOUT_EN
  // 20 tail-less words from bot: word 16 gets the tail bit forced, the grant
  // is released once, and words 17-20 start a new (still open) grant.
  task automatic test_timeout();
    int n;
    logic [DW-1:0] w, g;
    @(negedge clk); #1;
    err_pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      w = 11'h010 + 11'(i);
      src_q[1].push_back(w);
      exp_q.push_back((i == 16) ? (w | 11'h400) : w);
    end
    n = 0;
    while (got_q.size() < 20 && n < 300) begin @(negedge clk); n++; end
    checks++; if (got_q.size() < 20) begin errors++; $display("FAIL to_timeout got=%0d words exp=20", got_q.size()); end
    repeat (2) @(negedge clk);
    checks++; if (err_pulses !== 1) begin errors++; $display("FAIL to_err_pulses got=%0d exp=1", err_pulses); end
    if (got_cyc.size() >= 17) begin
      checks++; if (got_cyc[15] - got_cyc[14] !== 1 || got_cyc[16] - got_cyc[15] !== 2) begin
        errors++; $display("FAIL to_regrant gaps=%0d,%0d exp 1,2", got_cyc[15] - got_cyc[14], got_cyc[16] - got_cyc[15]);
      end
    end
    checks++; if (busy !== 1'b1 || grant_id !== 2'd1) begin
      errors++; $display("FAIL to_open_grant busy=%b grant=%0d exp 1/1", busy, grant_id);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      w = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== w) begin errors++; $display("FAIL to_word got=%h exp=%h", g, w); end
    end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask
`else
  // Without the timeout a 20-word packet passes whole, back to back.
  task automatic test_long_packet();
    int n;
    logic [DW-1:0] w, g;
    @(negedge clk); #1;
    err_pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      w = 11'h010 + 11'(i);
      if (i == 20) w = w | 11'h400;
      src_q[1].push_back(w);
      exp_q.push_back(w);
    end
    n = 0;
    while (got_q.size() < 20 && n < 300) begin @(negedge clk); n++; end
    checks++; if (got_q.size() < 20) begin errors++; $display("FAIL long_timeout got=%0d words exp=20", got_q.size()); end
    repeat (2) @(negedge clk);
    checks++; if (err_pulses !== 0) begin errors++; $display("FAIL long_err_pulses got=%0d exp=0", err_pulses); end
    if (got_cyc.size() >= 20) begin
      checks++; if (got_cyc[19] - got_cyc[0] !== 19) begin
        errors++; $display("FAIL long_throughput span=%0d exp=19", got_cyc[19] - got_cyc[0]);
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL long_release busy=%b exp=0", busy); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      w = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g !== w) begin errors++; $display("FAIL long_word got=%h exp=%h", g, w); end
    end
    exp_q.delete(); got_q.delete(); got_cyc.delete();
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    errors = 0;
    checks = 0;
    ready_mode = 0;
    reset = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_hold();
    test_reset_mid();
`ifdef PKT_TIMEOUT_EN
    test_timeout();
`else
    test_long_packet();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
